// File: rtl/bru_btb.sv
// rtl/bru_btb.sv - branch resolution unit with fetch PC register and BTB predictor
//
// Purpose:
//   Holds the fetch PC. A direct-mapped BTB with 2-bit saturating counters
//   predicts the next fetch PC. The EX-side logic resolves JAL/JALR/branches,
//   flags mispredictions, redirects the PC and trains the BTB.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pcwen               fetch advance enable (0 = IF stall)
//   o_pc                  current fetch PC
//   o_pred_taken          fetch-side prediction for o_pc
//   o_pred_target         predicted next PC (o_pc+4 when not taken)
//   i_ex_valid            EX holds a valid instruction
//   i_jal, i_jalr, i_brch EX instruction class
//   i_bfun3               branch funct3
//   i_rs1, i_rs2, i_imm   EX operands
//   i_ex_pc               EX instruction PC
//   i_ex_pred_taken       prediction carried with the EX instruction
//   i_ex_pred_target      predicted next PC carried with the EX instruction
//   o_redirect            misprediction, flush IF/ID
//   o_ex_taken            resolved taken/jump
//   o_perf_brch           (BRU_PERF_EN) resolved conditional branch count
//   o_perf_misp           (BRU_PERF_EN) redirect cycle count
//
// Optional feature macro: BRU_PERF_EN adds saturating performance counters.

module bru_btb #(
  parameter int          XLEN      = 64,
  parameter int          BTB_DEPTH = 16,
  parameter logic [63:0] RESET_PC  = 64'h80000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pcwen,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_ex_valid,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic            i_brch,
  input  logic [2:0]      i_bfun3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_target,
  output logic            o_redirect,
  output logic            o_ex_taken
`ifdef BRU_PERF_EN
  ,
  output logic [31:0]     o_perf_brch,
  output logic [31:0]     o_perf_misp
`endif
);

  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;

  // PC register
  logic [XLEN-1:0] pc_q, pc_d;

  // BTB storage
  logic            btb_valid_q  [BTB_DEPTH];
  logic [TAGW-1:0] btb_tag_q    [BTB_DEPTH];
  logic [XLEN-1:0] btb_target_q [BTB_DEPTH];
  logic [1:0]      btb_ctr_q    [BTB_DEPTH];

  // Fetch lookup
  logic [IDXW-1:0] f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;
  logic            f_taken;
  logic [XLEN-1:0] f_target;

  assign f_idx    = pc_q[IDXW+1:2];
  assign f_tag    = pc_q[XLEN-1:IDXW+2];
  assign f_hit    = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
  assign f_taken  = f_hit && btb_ctr_q[f_idx][1];
  assign f_target = f_taken ? btb_target_q[f_idx] : pc_q + XLEN'(4);

  assign o_pc          = pc_q;
  assign o_pred_taken  = f_taken;
  assign o_pred_target = f_target;

  // Resolution
  logic            cond;
  logic            act_taken;
  logic [XLEN-1:0] sum_pc, sum_rs, act_target, act_next;
  logic            redirect;

  always_comb begin
    cond = 1'b0;
    case (i_bfun3)
      3'b000:  cond = (i_rs1 == i_rs2);
      3'b001:  cond = (i_rs1 != i_rs2);
      3'b100:  cond = ($signed(i_rs1) <  $signed(i_rs2));
      3'b101:  cond = ($signed(i_rs1) >= $signed(i_rs2));
      3'b110:  cond = (i_rs1 <  i_rs2);
      3'b111:  cond = (i_rs1 >= i_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign sum_pc     = i_ex_pc + i_imm;
  assign sum_rs     = i_rs1 + i_imm;
  assign act_taken  = i_jal || i_jalr || (i_brch && cond);
  assign act_target = i_jalr ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;
  assign act_next   = act_taken ? act_target : i_ex_pc + XLEN'(4);
  assign redirect   = !i_rst && i_ex_valid && (act_next != i_ex_pred_target);

  assign o_redirect = redirect;
  assign o_ex_taken = !i_rst && i_ex_valid && act_taken;

  // The carried prediction bit is implied by the carried target; bit 0 of
  // the JALR sum is dropped by definition.
  logic unused_bits;
  assign unused_bits = ^{i_ex_pred_taken, sum_rs[0]};

  // PC next state: redirect beats the stall
  always_comb begin
    pc_d = pc_q;
    if (redirect)     pc_d = act_next;
    else if (i_pcwen) pc_d = f_target;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pc_q <= RESET_PC[XLEN-1:0];
    else       pc_q <= pc_d;
  end

  // BTB training
  logic [IDXW-1:0] e_idx;
  logic [TAGW-1:0] e_tag;
  logic            e_hit;
  logic [1:0]      e_ctr;
  logic            wr_en;
  logic            wr_valid;
  logic [XLEN-1:0] wr_target;
  logic [1:0]      wr_ctr;

  assign e_idx = i_ex_pc[IDXW+1:2];
  assign e_tag = i_ex_pc[XLEN-1:IDXW+2];
  assign e_hit = btb_valid_q[e_idx] && (btb_tag_q[e_idx] == e_tag);
  assign e_ctr = btb_ctr_q[e_idx];

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = btb_valid_q[e_idx];
    wr_target = btb_target_q[e_idx];
    wr_ctr    = e_ctr;
    if (i_ex_valid) begin
      if (i_jal || i_jalr) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_target = act_target;
        wr_ctr    = 2'b11;
      end else if (i_brch) begin
        if (e_hit) begin
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          if (act_taken) begin
            wr_target = act_target;
            wr_ctr    = (e_ctr == 2'b11) ? 2'b11 : e_ctr + 2'b01;
          end else begin
            wr_ctr    = (e_ctr == 2'b00) ? 2'b00 : e_ctr - 2'b01;
          end
        end else if (act_taken) begin
          wr_en     = 1'b1;
          wr_valid  = 1'b1;
          wr_target = act_target;
          wr_ctr    = 2'b10;
        end
      end else if (e_hit) begin
        // A non-control instruction aliasing a BTB entry: drop the entry
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_ctr_q[i]   <= 2'b01;
      end
    end else if (wr_en) begin
      btb_valid_q[e_idx]  <= wr_valid;
      btb_tag_q[e_idx]    <= e_tag;
      btb_target_q[e_idx] <= wr_target;
      btb_ctr_q[e_idx]    <= wr_ctr;
    end
  end

`ifdef BRU_PERF_EN
  logic [31:0] perf_brch_q, perf_brch_d;
  logic [31:0] perf_misp_q, perf_misp_d;

  always_comb begin
    perf_brch_d = perf_brch_q;
    perf_misp_d = perf_misp_q;
    if (i_ex_valid && i_brch && (perf_brch_q != 32'hFFFFFFFF))
      perf_brch_d = perf_brch_q + 32'd1;
    if (redirect && (perf_misp_q != 32'hFFFFFFFF))
      perf_misp_d = perf_misp_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perf_brch_q <= 32'd0;
      perf_misp_q <= 32'd0;
    end else begin
      perf_brch_q <= perf_brch_d;
      perf_misp_q <= perf_misp_d;
    end
  end

  assign o_perf_brch = perf_brch_q;
  assign o_perf_misp = perf_misp_q;
`endif

endmodule

// File: tb/tb_bru_btb.sv
// tb/tb_bru_btb.sv - self-checking bench for bru_btb
module tb_bru_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwen;
  logic [63:0] pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid, jal, jalr, brch;
  logic [2:0]  bfun3;
  logic [63:0] rs1, rs2, imm, ex_pc;
  logic        ex_pred_taken;
  logic [63:0] ex_pred_target;
  logic        redirect, ex_taken;
`ifdef BRU_PERF_EN
  logic [31:0] perf_brch, perf_misp;
`endif

  always #5 clk = ~clk;

  bru_btb dut (
    .i_clk(clk), .i_rst(rst), .i_pcwen(pcwen),
    .o_pc(pc), .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_ex_valid(ex_valid), .i_jal(jal), .i_jalr(jalr), .i_brch(brch),
    .i_bfun3(bfun3), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_ex_pc(ex_pc),
    .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_target(ex_pred_target),
    .o_redirect(redirect), .o_ex_taken(ex_taken)
`ifdef BRU_PERF_EN
    , .o_perf_brch(perf_brch), .o_perf_misp(perf_misp)
`endif
  );

  localparam int SEL_PC     = 0;
  localparam int SEL_PTAKEN = 1;
  localparam int SEL_PTGT   = 2;
  localparam int SEL_REDIR  = 3;
  localparam int SEL_TAKEN  = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_PC:     return pc;
      SEL_PTAKEN: return {63'd0, pred_taken};
      SEL_PTGT:   return pred_target;
      SEL_REDIR:  return {63'd0, redirect};
      SEL_TAKEN:  return {63'd0, ex_taken};
      default:    return '1;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then drain the scoreboard
  task automatic settle();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; jal = 0; jalr = 0; brch = 0; bfun3 = 3'b000;
    rs1 = 0; rs2 = 0; imm = 0; ex_pc = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic ex_set(input logic j, input logic jr, input logic b, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] c, input logic [63:0] im,
                        input logic [63:0] epc, input logic pt, input logic [63:0] ptg);
    ex_valid = 1; jal = j; jalr = jr; brch = b; bfun3 = f3;
    rs1 = a; rs2 = c; imm = im; ex_pc = epc; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  // Force the fetch PC to tgt via a mispredicted non-control instruction at tgt-4
  task automatic steer(input logic [63:0] tgt);
    ex_set(0, 0, 0, 3'b000, 0, 0, 0, tgt - 64'd4, 1, tgt + 64'h100);
    push_exp("steer_redirect", SEL_REDIR, 1);
    settle();
    tick();
    ex_idle();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic        taken;
  } cmp_t;

  cmp_t cmp_tab[6];

  initial begin
    cmp_tab[0] = '{3'b100, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b1}; // BLT  -1 < 1
    cmp_tab[1] = '{3'b110, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0}; // BLTU
    cmp_tab[2] = '{3'b111, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b1}; // BGEU
    cmp_tab[3] = '{3'b101, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0}; // BGE
    cmp_tab[4] = '{3'b010, 64'd3, 64'd3, 1'b0};                // reserved funct3
    cmp_tab[5] = '{3'b000, 64'd7, 64'd7, 1'b1};                // BEQ

    // Reset with a mispredicted JAL presented: outputs must stay quiet, no training
    rst = 1; pcwen = 1;
    ex_set(1, 0, 0, 3'b000, 0, 0, 64'h40, 64'h80000000, 0, 64'h80000004);
    push_exp("rst_redirect", SEL_REDIR, 0);
    push_exp("rst_ex_taken", SEL_TAKEN, 0);
    settle();
    tick();
    tick();
    rst = 0;
    ex_idle();
    push_exp("rst_pc", SEL_PC, 64'h80000000);
    push_exp("rst_ptaken", SEL_PTAKEN, 0);
    push_exp("rst_ptgt", SEL_PTGT, 64'h80000004);
    settle();
    tick();
    push_exp("seq_pc1", SEL_PC, 64'h80000004);
    push_exp("seq_ptgt1", SEL_PTGT, 64'h80000008);
    settle();
    tick();
    push_exp("seq_pc2", SEL_PC, 64'h80000008);
    settle();

    // JAL cold miss
    ex_set(1, 0, 0, 3'b000, 0, 0, 64'h40, 64'h80000010, 0, 64'h80000014);
    push_exp("jal_redirect", SEL_REDIR, 1);
    push_exp("jal_taken", SEL_TAKEN, 1);
    settle();
    tick();
    ex_idle();
    push_exp("jal_pc", SEL_PC, 64'h80000050);
    settle();
    steer(64'h80000010);
    push_exp("jal_fetch_pc", SEL_PC, 64'h80000010);
    push_exp("jal_fetch_ptaken", SEL_PTAKEN, 1);
    push_exp("jal_fetch_ptgt", SEL_PTGT, 64'h80000050);
    settle();

    // BNE training at 80000100, target 800000F8
    ex_set(0, 0, 1, 3'b001, 1, 0, 64'hFFFFFFFFFFFFFFF8, 64'h80000100, 0, 64'h80000104);
    push_exp("bne1_redirect", SEL_REDIR, 1);
    push_exp("bne1_taken", SEL_TAKEN, 1);
    settle();
    tick();
    ex_idle();
    push_exp("bne1_pc", SEL_PC, 64'h800000F8);
    settle();
    tick();
    tick();
    push_exp("bne_fetch_pc", SEL_PC, 64'h80000100);
    push_exp("bne_fetch_ptaken", SEL_PTAKEN, 1);
    push_exp("bne_fetch_ptgt", SEL_PTGT, 64'h800000F8);
    settle();
    pcwen = 0;
    for (int k = 0; k < 2; k++) begin
      ex_set(0, 0, 1, 3'b001, 1, 0, 64'hFFFFFFFFFFFFFFF8, 64'h80000100, 1, 64'h800000F8);
      push_exp("bne_hit_redirect", SEL_REDIR, 0);
      push_exp("bne_hit_taken", SEL_TAKEN, 1);
      settle();
      tick();
    end
    ex_idle();
    push_exp("bne_stall_pc", SEL_PC, 64'h80000100);
    push_exp("bne_stall_ptaken", SEL_PTAKEN, 1);
    settle();

    // First not-taken: 11 -> 10, still predicted taken
    ex_set(0, 0, 1, 3'b001, 5, 5, 64'hFFFFFFFFFFFFFFF8, 64'h80000100, 1, 64'h800000F8);
    push_exp("bne_nt1_redirect", SEL_REDIR, 1);
    push_exp("bne_nt1_taken", SEL_TAKEN, 0);
    settle();
    tick();
    ex_idle();
    push_exp("bne_nt1_pc", SEL_PC, 64'h80000104);
    settle();
    steer(64'h80000100);
    push_exp("ctr10_ptaken", SEL_PTAKEN, 1);
    settle();

    // Second not-taken: 10 -> 01, now predicted not taken
    ex_set(0, 0, 1, 3'b001, 5, 5, 64'hFFFFFFFFFFFFFFF8, 64'h80000100, 1, 64'h800000F8);
    push_exp("bne_nt2_redirect", SEL_REDIR, 1);
    settle();
    tick();
    ex_idle();
    steer(64'h80000100);
    push_exp("ctr01_ptaken", SEL_PTAKEN, 0);
    push_exp("ctr01_ptgt", SEL_PTGT, 64'h80000104);
    settle();

    // Signed vs unsigned compares (combinational only)
    foreach (cmp_tab[k]) begin
      ex_set(0, 0, 1, cmp_tab[k].f3, cmp_tab[k].a, cmp_tab[k].b, 64'h20,
             64'h80000300, 0, 64'h80000304);
      push_exp($sformatf("cmp_taken_f3_%0d", cmp_tab[k].f3), SEL_TAKEN, {63'd0, cmp_tab[k].taken});
      settle();
    end
    ex_idle();

    // JALR with bit0 cleared, redirect while stalled
    ex_set(0, 1, 0, 3'b000, 64'h80000203, 0, 64'd4, 64'h80000400, 0, 64'h80000404);
    push_exp("jalr_redirect", SEL_REDIR, 1);
    push_exp("jalr_taken", SEL_TAKEN, 1);
    settle();
    tick();
    ex_idle();
    push_exp("jalr_pc", SEL_PC, 64'h80000206);
    settle();

    // Stall holds the PC
    for (int k = 0; k < 3; k++) begin
      tick();
      push_exp($sformatf("stall_pc_%0d", k), SEL_PC, 64'h80000206);
      settle();
    end

    // Alias scrub of the 80000010 entry
    steer(64'h80000010);
    push_exp("alias_pre_ptaken", SEL_PTAKEN, 1);
    settle();
    ex_set(0, 0, 0, 3'b000, 0, 0, 0, 64'h80000010, 1, 64'h80000050);
    push_exp("alias_redirect", SEL_REDIR, 1);
    push_exp("alias_same_cycle_ptaken", SEL_PTAKEN, 1);
    settle();
    tick();
    ex_idle();
    push_exp("alias_redir_pc", SEL_PC, 64'h80000014);
    settle();
    steer(64'h80000010);
    push_exp("alias_post_pc", SEL_PC, 64'h80000010);
    push_exp("alias_post_ptaken", SEL_PTAKEN, 0);
    push_exp("alias_post_ptgt", SEL_PTGT, 64'h80000014);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bru_btb.md
Name: bru_btb

Overview:
- Next-generation branch resolution unit: owns the fetch PC register and adds dynamic prediction.
- Fetch side: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry predicts the next PC.
- Execute side: resolves JAL, JALR and conditional branches, detects mispredictions, redirects the PC and trains the BTB.
- Sits between the IF stage (drives o_pc) and the EX stage (receives resolved operands plus the prediction that travelled down the pipe).

Parameters:
- XLEN, 64, datapath and PC width in bits.
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2. IDXW = log2(BTB_DEPTH).
- RESET_PC, 64'h80000000, PC value loaded on reset; truncated to XLEN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_pcwen  in  1  fetch advance enable; 0 = IF stall
- o_pc  out  XLEN  current fetch PC
- o_pred_taken  out  1  fetch-side prediction for o_pc
- o_pred_target  out  XLEN  predicted next PC for o_pc (o_pc+4 when not taken)
- i_ex_valid  in  1  EX holds a valid instruction this cycle
- i_jal  in  1  EX instruction is JAL
- i_jalr  in  1  EX instruction is JALR
- i_brch  in  1  EX instruction is a conditional branch
- i_bfun3  in  3  branch funct3
- i_rs1, i_rs2, i_imm, i_ex_pc  in  XLEN each  EX operands and EX PC
- i_ex_pred_taken  in  1  prediction carried with the EX instruction
- i_ex_pred_target  in  XLEN  predicted next PC carried with the EX instruction
- o_redirect  out  1  misprediction; IF/ID must be flushed
- o_ex_taken  out  1  resolved taken/jump for the EX instruction

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_pc = RESET_PC.
  - All BTB valid bits = 0; all counters = 2'b01 (weakly not taken).
  - Perf counters = 0.
  - During reset o_redirect = 0 and o_ex_taken = 0; they are forced by i_rst, not registered.
  - Reset overrides every other event in the same cycle.
- BTB entry: {valid, tag = pc[XLEN-1:IDXW+2], target[XLEN-1:0], ctr[1:0]}.
- Index = pc[IDXW+1:2]. PC bits [1:0] are ignored for indexing.
- Fetch lookup (combinational on o_pc):
  - hit = valid && tag match.
  - o_pred_taken = hit && ctr[1].
  - o_pred_target = o_pred_taken ? entry.target : o_pc+4.
- Resolution (combinational, only when i_ex_valid):
  - Branch conditions:
    - BEQ 000: rs1==rs2.
    - BNE 001: rs1!=rs2.
    - BLT 100 / BGE 101: XLEN-bit signed compare.
    - BLTU 110 / BGEU 111: unsigned compare.
    - funct3 010/011: not taken.
  - act_taken = i_jal || i_jalr || (i_brch && cond).
  - act_target:
    - JALR: (rs1+imm) with bit0 cleared.
    - JAL and branches: ex_pc+imm.
    - All additions wrap modulo 2^XLEN.
  - act_next = act_taken ? act_target : ex_pc+4.
  - o_ex_taken = act_taken.
  - o_redirect = i_ex_valid && (act_next != i_ex_pred_target). Non-control instructions therefore redirect only if they were mispredicted taken.
- PC update, per clock edge, in priority order:
  - i_rst.
  - o_redirect: pc <= act_next, regardless of i_pcwen.
  - i_pcwen: pc <= o_pred_target.
  - Otherwise pc holds.
- Redirect latency: o_pc shows the corrected PC on the cycle after o_redirect.
- BTB update (registered, at the edge, only when i_ex_valid and not reset), at index/tag of i_ex_pc:
  - JAL/JALR: write valid=1, tag, target=act_target, ctr=2'b11.
  - Branch hitting the BTB: ctr increments (saturating at 11) if taken, decrements (saturating at 00) if not taken. Target is rewritten when taken.
  - Branch missing the BTB, taken: allocate/replace entry with valid=1, target=act_target, ctr=2'b10.
  - Branch missing the BTB, not taken: no write.
  - Non-control instruction whose tag hits: clear valid (alias scrub).
- Same-cycle read/write of the same index: the fetch lookup sees the pre-update contents; the new value is visible next cycle.
- Stall with no redirect: PC holds; BTB training still occurs.

Optional Feature:
- Macro BRU_PERF_EN.
- When defined, the block adds:
  - o_perf_brch (32b): count of resolved conditional branches.
  - o_perf_misp (32b): count of o_redirect cycles.
  - Both are saturating at 32'hFFFFFFFF, cleared by i_rst, and increment at the clock edge.
- When undefined, neither port nor counter exists.

Test Plan:
- Reset: i_rst=1 for 2 cycles, then released with i_pcwen=1 and i_ex_valid=0 -> o_pc = 80000000, 80000004, 80000008; o_pred_taken=0.
- JAL cold miss: EX pc=80000010, imm=0x40, pred_target=80000014 -> o_redirect=1, next o_pc=80000050. A later fetch of 80000010 gives o_pred_taken=1, o_pred_target=80000050.
- Branch training: BNE at 80000100, imm=-8, rs1=1, rs2=0, taken 3 times -> first resolution redirects; once the entry exists the fetch prediction is taken with ctr=11. One not-taken resolution -> ctr=10, still predicted taken, and that resolution redirects to 80000104.
- Signed vs unsigned: rs1=FFFF...FFFF, rs2=1 -> BLT taken, BLTU not taken; BGEU taken.
- JALR: rs1=80000203, imm=4 -> target 80000206 (bit0 cleared); redirect applied while i_pcwen=0.
- Stall plus alias: i_pcwen=0 for 3 cycles with no redirect -> o_pc constant. A non-control instruction at a BTB-hit PC clears the entry; the next fetch of that PC has o_pred_taken=0.
